spart_word_link: RTL
====================

# spart_word_link

Parametrised board-to-board serial word link: transmits and receives multi-byte words over a single UART-style wire pair (start, 8 data LSB-first, optional even parity, stop). It generalises the fixed 3-byte test link into a configurable word width with a receive FIFO, parity checking, framing/timeout detection and valid/ready handshakes. It sits between the processor's interrupt/interface logic and the GPIO pins that cross-connect the two boards.

## Interface
- WORD_BYTES, 3, bytes per word; word width W = 8*WORD_BYTES; range 1..4
- FIFO_DEPTH, 4, receive FIFO entries; power of two, ≥2
- PARITY_EN, 0, 1 = append/check an even-parity bit after each data byte
- TIMEOUT_BITS, 16, idle bit-periods allowed between bytes of one word before the partial word is discarded

- sys_clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- baud  in  16  cycles per bit; values <4 treated as 4; latched at TX accept and at RX start detection
- tx_valid  in  1  word offered
- tx_ready  out  1  transmitter idle; accept on tx_valid & tx_ready
- tx_data  in  W  word; byte 0 = tx_data[7:0] sent first
- txd  out  1  serial out, idle high
- rxd  in  1  serial in, asynchronous
- rx_valid  out  1  FIFO not empty
- rx_ready  in  1  pop on rx_valid & rx_ready
- rx_data  out  W  FIFO head (show-ahead)
- rx_frame_err  out  1  1-cycle pulse: bad stop bit, false start, or inter-byte timeout
- rx_parity_err  out  1  1-cycle pulse: parity mismatch (PARITY_EN=1 only)
- rx_overflow  out  1  1-cycle pulse: completed word dropped, FIFO full

## Operation
- Reset: txd=1, tx_ready=1, rx_valid=0, rx_data=0, all error pulses 0, FIFO empty, both FSMs IDLE, byte counters 0. Reset mid-frame aborts immediately; txd returns high next cycle.
- TX FSM: IDLE → START → DATA(8 bits) → [PARITY] → STOP → next byte START or IDLE. Bytes sent back-to-back, no inter-byte gap. tx_data captured at accept; later changes ignored. tx_ready low from the cycle after accept until the word completes.
- RX sync: rxd through 2 flops; falling edge on synchronised value in IDLE starts a byte.
- RX FSM: IDLE → START (sample at midpoint; if high → false start, rx_frame_err pulse, IDLE) → DATA(8 samples) → [PARITY] → STOP. Stop sampled low → rx_frame_err. Parity mismatch → rx_parity_err. Any error discards the partial word; byte counter → 0.
- After stop-bit sample the RX FSM returns to IDLE that cycle, ready for the next edge.
- Good byte stored at byte slot = byte counter; counter increments; at WORD_BYTES the word is pushed and counter → 0.
- Timeout: counter ≠0 and RX IDLE for TIMEOUT_BITS*baud cycles → discard partial word, rx_frame_err pulse, counter → 0. Counter = 0 never times out.
- FIFO: push when full and no pop in same cycle → word dropped, rx_overflow pulse, contents unchanged. Push and pop in same cycle when full → both succeed, no overflow. Pop when empty ignored.
- If parity error and stop error occur on one byte, both pulses fire the same cycle.

## Timing
- TX: accept at cycle t; txd=0 from t+1; each bit held exactly baud cycles; word length L = WORD_BYTES*(10+PARITY_EN)*baud; tx_ready=1 at t+1+L; earliest next accept then.
- RX: midpoint sample floor(baud/2) cycles after the synchronised falling edge, then every baud cycles. Sync adds 2 cycles latency from pin.
- Push occurs cycle after final stop sample; rx_valid=1 and rx_data valid the cycle after push.
- Error pulses asserted the cycle after the offending sample (timeout: cycle after expiry).
- Pop: rx_data shows next entry (or rx_valid=0) the cycle after rx_valid & rx_ready.

## Test plan
- Loopback txd→rxd, WORD_BYTES=3, baud=16, PARITY_EN=0: send 0xA5C33C → rx_valid rises, rx_data=0xA5C33C; tx_ready high exactly 480 cycles after accept+1.
- PARITY_EN=1, baud=8: send 0x01_00_FF; inject flipped parity on byte 1 → one rx_parity_err pulse, no word pushed; next clean word 0x123456 received intact.
- Drive stop bit low on byte 0 → rx_frame_err pulse, counter resets; 200 ns glitch low shorter than baud/2 → false start, rx_frame_err, no push.
- Send 2 bytes then hold rxd high > TIMEOUT_BITS*baud → rx_frame_err after timeout; following full word received correctly.
- FIFO_DEPTH=4, rx_ready=0: 5 words → 4 stored, rx_overflow pulse on 5th; then pop with push on same cycle when full → no overflow, order preserved.
- baud=2 → behaves as 4 (bit period 4 cycles); reset asserted mid-word → txd=1, tx_ready=1 next cycle, FIFO empty.

Source files
------------

// File: rtl/spart_word_link_if.sv
// spart_word_link_if: word-level tx/rx valid-ready handshakes of the serial word link
// master: user side (drives tx_valid/tx_data/rx_ready); slave: link side (drives tx_ready/rx_valid/rx_data)
interface spart_word_link_if #(parameter int W = 24);
  logic tx_valid;
  logic tx_ready;
  logic [W-1:0] tx_data;
  logic rx_valid;
  logic rx_ready;
  logic [W-1:0] rx_data;
  modport master (output tx_valid, tx_data, rx_ready, input tx_ready, rx_valid, rx_data);
  modport slave (input tx_valid, tx_data, rx_ready, output tx_ready, rx_valid, rx_data);
endinterface

// File: rtl/spart_word_link.sv
// spart_word_link: UART-style multi-byte word link with rx FIFO, parity, framing and inter-byte timeout
// ports: sys_clk/rst (sync, active high); baud = cycles per bit (min 4); txd/rxd serial pins;
//        bus = word handshakes; rx_frame_err/rx_parity_err/rx_overflow = one-cycle error pulses
module spart_word_link #(
  parameter int WORD_BYTES = 3,
  parameter int FIFO_DEPTH = 4,
  parameter bit PARITY_EN = 1'b0,
  parameter int TIMEOUT_BITS = 16
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic [15:0] baud,
  output logic txd,
  input  logic rxd,
  output logic rx_frame_err,
  output logic rx_parity_err,
  output logic rx_overflow,
  spart_word_link_if.slave bus
);
  localparam int W = 8 * WORD_BYTES;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = WORD_BYTES > 1 ? $clog2(WORD_BYTES) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic [15:0] bd;
  assign bd = baud < 16'd4 ? 16'd4 : baud;
  state_t tx_st;
  logic [15:0] tx_baud, tx_cnt;
  logic [2:0] tx_bit;
  logic [W-1:0] tx_sh;
  logic tx_par, tx_rdy;
  logic [BW-1:0] tx_byte;
  assign bus.tx_ready = tx_rdy;
  // tx_sh shifts one bit per data bit, so bit 0 always holds the bit on (or next on) the wire
  always_ff @(posedge sys_clk)
    if (rst) begin
      tx_st <= IDLE;
      txd <= 1'b1;
      tx_rdy <= 1'b1;
      tx_baud <= 16'd4;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh <= '0;
      tx_par <= 1'b0;
      tx_byte <= '0;
    end else if (tx_st == IDLE) begin
      if (bus.tx_valid && tx_rdy) begin
        tx_st <= START;
        txd <= 1'b0;
        tx_rdy <= 1'b0;
        tx_baud <= bd;
        tx_cnt <= '0;
        tx_byte <= '0;
        tx_sh <= bus.tx_data;
      end
    end else if (tx_cnt != tx_baud - 16'd1) tx_cnt <= tx_cnt + 16'd1;
    else begin
      tx_cnt <= '0;
      case (tx_st)
        START: begin
          tx_st <= DATA;
          tx_bit <= '0;
          txd <= tx_sh[0];
          tx_par <= tx_sh[0];
        end
        DATA: begin
          tx_sh <= tx_sh >> 1;
          tx_bit <= tx_bit + 3'd1;
          if (tx_bit == 3'd7) begin
            tx_st <= PARITY_EN ? PARITY : STOP;
            txd <= PARITY_EN ? tx_par : 1'b1;
          end else begin
            txd <= tx_sh[1];
            tx_par <= tx_par ^ tx_sh[1];
          end
        end
        PARITY: begin
          tx_st <= STOP;
          txd <= 1'b1;
        end
        default:
          if (tx_byte == BW'(WORD_BYTES - 1)) begin
            tx_st <= IDLE;
            tx_rdy <= 1'b1;
          end else begin
            tx_byte <= tx_byte + 1'b1;
            tx_st <= START;
            txd <= 1'b0;
          end
      endcase
    end
  logic r1, r2, r3;
  state_t rx_st;
  logic [15:0] rx_baud, rx_cnt;
  logic [2:0] rx_bit;
  logic [7:0] rx_sh;
  logic rx_par, par_bad, push, fall, samp, tmo;
  logic [BW-1:0] rx_byte;
  logic [W-1:0] word;
  logic [31:0] idle_cnt, tmo_lim;
  assign fall = r3 & ~r2;
  // rx_cnt restarts at 1, so the start sample lands baud/2 cycles after r2 first went low
  assign samp = rx_st == START ? rx_cnt == (rx_baud >> 1) - 16'd1 : rx_cnt == rx_baud;
  assign tmo_lim = 32'(TIMEOUT_BITS) * 32'(rx_baud);
  assign tmo = rx_st == IDLE && rx_byte != '0 && idle_cnt == tmo_lim - 32'd1;
  always_ff @(posedge sys_clk)
    if (rst) begin
      r1 <= 1'b1;
      r2 <= 1'b1;
      r3 <= 1'b1;
      rx_st <= IDLE;
      rx_baud <= 16'd4;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh <= '0;
      rx_par <= 1'b0;
      par_bad <= 1'b0;
      rx_byte <= '0;
      word <= '0;
      push <= 1'b0;
      idle_cnt <= '0;
      rx_frame_err <= 1'b0;
      rx_parity_err <= 1'b0;
    end else begin
      r1 <= rxd;
      r2 <= r1;
      r3 <= r2;
      push <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_parity_err <= 1'b0;
      idle_cnt <= rx_st == IDLE && rx_byte != '0 && !tmo ? idle_cnt + 32'd1 : '0;
      if (tmo) begin
        rx_frame_err <= 1'b1;
        rx_byte <= '0;
      end
      case (rx_st)
        IDLE:
          if (fall) begin
            rx_st <= START;
            rx_cnt <= 16'd1;
            rx_baud <= bd;
          end
        default:
          if (!samp) rx_cnt <= rx_cnt + 16'd1;
          else begin
            rx_cnt <= 16'd1;
            case (rx_st)
              START:
                if (r2) begin
                  rx_st <= IDLE;
                  rx_frame_err <= 1'b1;
                  rx_byte <= '0;
                end else begin
                  rx_st <= DATA;
                  rx_bit <= '0;
                  rx_par <= 1'b0;
                end
              DATA: begin
                rx_sh <= {r2, rx_sh[7:1]};
                rx_par <= rx_par ^ r2;
                rx_bit <= rx_bit + 3'd1;
                par_bad <= 1'b0;
                if (rx_bit == 3'd7) rx_st <= PARITY_EN ? PARITY : STOP;
              end
              PARITY: begin
                par_bad <= r2 != rx_par;
                rx_st <= STOP;
              end
              default: begin
                // parity result is held until the stop sample so both error pulses coincide
                rx_st <= IDLE;
                rx_frame_err <= ~r2;
                rx_parity_err <= par_bad;
                if (!r2 || par_bad) rx_byte <= '0;
                else begin
                  word[{rx_byte, 3'b000} +: 8] <= rx_sh;
                  if (rx_byte == BW'(WORD_BYTES - 1)) begin
                    rx_byte <= '0;
                    push <= 1'b1;
                  end else rx_byte <= rx_byte + 1'b1;
                end
              end
            endcase
          end
      endcase
    end
  logic [W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic nz, full, pop, wr;
  assign nz = cnt != '0;
  assign full = cnt == (AW + 1)'(FIFO_DEPTH);
  assign pop = nz && bus.rx_ready;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign wr = push && (!full || pop);
  assign bus.rx_valid = nz;
  assign bus.rx_data = nz ? mem[rp] : '0;
  always_ff @(posedge sys_clk)
    if (wr) mem[wp] <= word;
  always_ff @(posedge sys_clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      rx_overflow <= 1'b0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW + 1)'(wr) - (AW + 1)'(pop);
      rx_overflow <= push && full && !pop;
    end
endmodule
